// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and the NOP bundle for pipeline boundary registers
package pipe_pkg;

   localparam int MEM_CTRL_W     = 12;
   localparam int WB_CTRL_W      = 7;
   localparam int STAGE_BUNDLE_W = MEM_CTRL_W + WB_CTRL_W;

   // All-zero bundle is the architectural NOP: no register write, no memory access.
   localparam logic [STAGE_BUNDLE_W-1:0] NOP_BUNDLE = '0;

endpackage

// File: rtl/pipe_stage_cell.sv
// rtl/pipe_stage_cell.sv - one pipeline stage: valid bit, bubble zeroing, flush/stall muxing
module pipe_stage_cell
   import pipe_pkg::*;
#(
   parameter int DATA_W = STAGE_BUNDLE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid <= 1'b0;
         out_data  <= DATA_W'(NOP_BUNDLE);
      end else if (!stall) begin
         out_valid <= in_valid;
         // A bubble must never carry stale control bits downstream.
         out_data  <= in_valid ? in_data : DATA_W'(NOP_BUNDLE);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - DEPTH-stage pipeline boundary register with stall/flush
// Optional stall/flush performance counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = STAGE_BUNDLE_W,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   if (DEPTH < 1 || DEPTH > 8 || CNT_W < 1) begin : g_bad_param
      $error("pipe_stage_reg: DEPTH must be 1..8 and CNT_W at least 1");
   end

   // Element 0 is the input side; element k+1 is the output of stage k.
   logic [DEPTH:0]    v_chain;
   logic [DATA_W-1:0] d_chain [DEPTH+1];

   assign v_chain[0] = in_valid;
   assign d_chain[0] = in_data;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipe_stage_cell #(
         .DATA_W (DATA_W)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .stall     (stall),
         .flush     (flush),
         .in_valid  (v_chain[k]),
         .in_data   (d_chain[k]),
         .out_valid (v_chain[k+1]),
         .out_data  (d_chain[k+1])
      );
   end

   assign in_ready  = !stall || flush;
   assign out_valid = v_chain[DEPTH];
   assign out_data  = d_chain[DEPTH];

`ifdef PIPE_STAGE_PERF_EN
   // Saturating counters; a flush cycle is never counted as a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && !flush && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table-driven bench for pipe_stage_reg at DEPTH 1, 2 and 3
module tb_pipe_stage_reg;

   localparam int W = 19;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         stall;
   logic         flush;
   logic         rdy1, rdy2, rdy3;
   logic         v1, v2, v3;
   logic [W-1:0] d1, d2, d3;
`ifdef PIPE_STAGE_PERF_EN
   logic [3:0]   sc1, fc1, sc2, fc2, sc3, fc3;
`endif

   int checks = 0;
   int passes = 0;

   pipe_stage_reg #(.DATA_W(W), .DEPTH(1), .CNT_W(4)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .stall(stall), .flush(flush), .in_ready(rdy1),
      .out_valid(v1), .out_data(d1)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );

   pipe_stage_reg #(.DATA_W(W), .DEPTH(2), .CNT_W(4)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .stall(stall), .flush(flush), .in_ready(rdy2),
      .out_valid(v2), .out_data(d2)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
   );

   pipe_stage_reg #(.DATA_W(W), .DEPTH(3), .CNT_W(4)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .stall(stall), .flush(flush), .in_ready(rdy3),
      .out_valid(v3), .out_data(d3)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      logic         rst;
      logic         iv;
      logic [W-1:0] din;
      logic         stall;
      logic         flush;
      logic         rdy;
      logic [W-1:0] e1;
      logic [W-1:0] e2;
      logic [W-1:0] e3;
      logic [3:0]   esc;
      logic [3:0]   efc;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic r, input logic iv, input logic [W-1:0] din,
                               input logic st, input logic fl, input logic rdy,
                               input logic [W-1:0] e1, input logic [W-1:0] e2,
                               input logic [W-1:0] e3, input logic [3:0] esc,
                               input logic [3:0] efc);
      vec_t t;
      t.rst = r; t.iv = iv; t.din = din; t.stall = st; t.flush = fl; t.rdy = rdy;
      t.e1 = e1; t.e2 = e2; t.e3 = e3; t.esc = esc; t.efc = efc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // Valid data in this bench is always nonzero, so valid is expected exactly when data is nonzero.
   task automatic chk_outs(input string tag, input logic [W-1:0] e1, input logic [W-1:0] e2,
                           input logic [W-1:0] e3);
      chk({tag, " v1"}, 32'(v1), 32'(e1 != '0));
      chk({tag, " d1"}, 32'(d1), 32'(e1));
      chk({tag, " v2"}, 32'(v2), 32'(e2 != '0));
      chk({tag, " d2"}, 32'(d2), 32'(e2));
      chk({tag, " v3"}, 32'(v3), 32'(e3 != '0));
      chk({tag, " d3"}, 32'(d3), 32'(e3));
   endtask

   initial begin
      //             rst iv din       st fl rdy e1        e2        e3        sc fc
      tbl[0]  = mk(1, 1, 19'h7FFFF, 0, 0, 1, 19'h0,     19'h0,     19'h0,     0, 0);
      tbl[1]  = mk(1, 1, 19'h7FFFF, 0, 0, 1, 19'h0,     19'h0,     19'h0,     0, 0);
      tbl[2]  = mk(0, 1, 19'h00001, 0, 0, 1, 19'h00001, 19'h0,     19'h0,     0, 0);
      tbl[3]  = mk(0, 1, 19'h00002, 0, 0, 1, 19'h00002, 19'h00001, 19'h0,     0, 0);
      tbl[4]  = mk(0, 1, 19'h00003, 0, 0, 1, 19'h00003, 19'h00002, 19'h00001, 0, 0);
      tbl[5]  = mk(0, 0, 19'h55555, 0, 0, 1, 19'h0,     19'h00003, 19'h00002, 0, 0);
      tbl[6]  = mk(0, 0, 19'h55555, 0, 0, 1, 19'h0,     19'h0,     19'h00003, 0, 0);
      tbl[7]  = mk(0, 0, 19'h55555, 0, 0, 1, 19'h0,     19'h0,     19'h0,     0, 0);
      tbl[8]  = mk(0, 1, 19'h0ABCD, 0, 0, 1, 19'h0ABCD, 19'h0,     19'h0,     0, 0);
      tbl[9]  = mk(0, 1, 19'h12345, 1, 0, 0, 19'h0ABCD, 19'h0,     19'h0,     1, 0);
      tbl[10] = mk(0, 1, 19'h12345, 1, 0, 0, 19'h0ABCD, 19'h0,     19'h0,     2, 0);
      tbl[11] = mk(0, 1, 19'h12345, 1, 0, 0, 19'h0ABCD, 19'h0,     19'h0,     3, 0);
      tbl[12] = mk(0, 1, 19'h12345, 1, 0, 0, 19'h0ABCD, 19'h0,     19'h0,     4, 0);
      tbl[13] = mk(0, 1, 19'h12345, 0, 0, 1, 19'h12345, 19'h0ABCD, 19'h0,     4, 0);
      tbl[14] = mk(0, 1, 19'h00777, 0, 0, 1, 19'h00777, 19'h12345, 19'h0ABCD, 4, 0);
      tbl[15] = mk(0, 1, 19'h7FFFF, 1, 1, 1, 19'h0,     19'h0,     19'h0,     4, 1);
      tbl[16] = mk(0, 1, 19'h00011, 0, 0, 1, 19'h00011, 19'h0,     19'h0,     4, 1);
      tbl[17] = mk(0, 1, 19'h00022, 0, 0, 1, 19'h00022, 19'h00011, 19'h0,     4, 1);
      tbl[18] = mk(0, 1, 19'h00033, 0, 1, 1, 19'h0,     19'h0,     19'h0,     4, 2);
      tbl[19] = mk(0, 1, 19'h00044, 0, 0, 1, 19'h00044, 19'h0,     19'h0,     4, 2);
      tbl[20] = mk(1, 1, 19'h00055, 0, 0, 1, 19'h0,     19'h0,     19'h0,     0, 0);
      tbl[21] = mk(0, 0, 19'h00000, 0, 0, 1, 19'h0,     19'h0,     19'h0,     0, 0);

      rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].din;
         stall = tbl[i].stall; flush = tbl[i].flush;
         #1;
         chk({tag, " in_ready"}, 32'(rdy3), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         chk_outs(tag, tbl[i].e1, tbl[i].e2, tbl[i].e3);
`ifdef PIPE_STAGE_PERF_EN
         chk({tag, " stall_cnt"}, 32'(sc2), 32'(tbl[i].esc));
         chk({tag, " flush_cnt"}, 32'(fc2), 32'(tbl[i].efc));
`endif
         @(negedge clk);
      end

      // Long stall: output held for every stalled cycle, counter saturates at 15.
      rst = 1'b0; in_valid = 1'b1; in_data = 19'h0ABCD; stall = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      chk("preload d1", 32'(d1), 32'h0ABCD);
      @(negedge clk);
      in_data = 19'h12345; stall = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         #1;
         chk($sformatf("longstall%0d in_ready", n), 32'(rdy1), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("longstall%0d v1", n), 32'(v1), 32'h1);
         chk($sformatf("longstall%0d d1", n), 32'(d1), 32'h0ABCD);
`ifdef PIPE_STAGE_PERF_EN
         chk($sformatf("longstall%0d stall_cnt", n), 32'(sc1), (n < 15) ? 32'(n) : 32'd15);
`endif
         @(negedge clk);
      end
      stall = 1'b0;
      @(posedge clk); #1;
      chk("release d1", 32'(d1), 32'h12345);
      chk("release d2", 32'(d2), 32'h0ABCD);
      chk("release v3", 32'(v3), 32'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk("release stall_cnt", 32'(sc1), 32'd15);
      chk("release flush_cnt", 32'(fc1), 32'd0);
`endif
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
